// File: rtl/nand_if_pkg.sv
// Shared definitions for the NAND command/address latch decoder.
// Holds the FSM state encoding, the cycle classification type and helper,
// the standard opcode constants and the default number of address cycles.
package nand_if_pkg;

    // Address cycles that follow a command when no override is given.
    localparam int DEFAULT_ADDR_BYTES = 4;

    // Decoder FSM: waiting for a command, or collecting address bytes.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ADDR = 1'b1
    } state_e;

    // What a single WEx-latched bus cycle represents.
    typedef enum logic [1:0] {
        KIND_DATA    = 2'b00,
        KIND_CMD     = 2'b01,
        KIND_ADDR    = 2'b10,
        KIND_ILLEGAL = 2'b11
    } cycle_kind_e;

    // Standard NAND opcodes.
    localparam logic [7:0] OP_READ1       = 8'h00;
    localparam logic [7:0] OP_READ2       = 8'h30;
    localparam logic [7:0] OP_PROGRAM     = 8'h80;
    localparam logic [7:0] OP_PROG_CONFIRM = 8'h10;
    localparam logic [7:0] OP_ERASE       = 8'h60;
    localparam logic [7:0] OP_STATUS      = 8'h70;
    localparam logic [7:0] OP_RESET       = 8'hFF;

    // Classify a latched cycle from its CLE/ALE levels.
    function automatic cycle_kind_e classify_cycle(input logic cle, input logic ale);
        cycle_kind_e kind;
        case ({cle, ale})
            2'b10:   kind = KIND_CMD;
            2'b01:   kind = KIND_ADDR;
            2'b11:   kind = KIND_ILLEGAL;
            default: kind = KIND_DATA;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/nand_latch_decoder_if.sv
// Bus bundle between a NAND command/address initiator and the latch decoder.
// Pin side:    CEx (active-low), CLEx, ALEx, WEx (active-low), IOXx[7:0].
// Result side: cmd_out/cmd_valid, addr_out/addr_valid, proto_err.
// master = initiator / bench (drives pins), slave = decoder (drives results).
interface nand_latch_decoder_if #(
    parameter int ADDR_BYTES = nand_if_pkg::DEFAULT_ADDR_BYTES
);
    logic                      CEx;
    logic                      CLEx;
    logic                      ALEx;
    logic                      WEx;
    logic [7:0]                IOXx;
    logic [7:0]                cmd_out;
    logic                      cmd_valid;
    logic [8*ADDR_BYTES-1:0]   addr_out;
    logic                      addr_valid;
    logic                      proto_err;

    modport master (
        output CEx, CLEx, ALEx, WEx, IOXx,
        input  cmd_out, cmd_valid, addr_out, addr_valid, proto_err
    );

    modport slave (
        input  CEx, CLEx, ALEx, WEx, IOXx,
        output cmd_out, cmd_valid, addr_out, addr_valid, proto_err
    );
endinterface

// File: rtl/nand_pin_sync.sv
// Multi-stage synchronizer for the NAND control pins and IO bus, plus
// rising-edge detection of the synchronized WEx and CEx.
// Ports: clk, reset (async active-low); *_pin raw inputs; *_sync last
// synchronizer stage; we_rise / ce_rise single-cycle edge indications.
// WEx and CEx (active-low) reset to 1 so reset release never looks like an edge.
module nand_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce_pin,
    input  logic       cle_pin,
    input  logic       ale_pin,
    input  logic       we_pin,
    input  logic [7:0] io_pin,
    output logic       ce_sync,
    output logic       cle_sync,
    output logic       ale_sync,
    output logic [7:0] io_sync,
    output logic       we_rise,
    output logic       ce_rise
);
    logic [SYNC_STAGES-1:0]       ce_sync_r;
    logic [SYNC_STAGES-1:0]       cle_sync_r;
    logic [SYNC_STAGES-1:0]       ale_sync_r;
    logic [SYNC_STAGES-1:0]       we_sync_r;
    logic [SYNC_STAGES-1:0][7:0]  io_sync_r;
    logic                         we_prev_r;
    logic                         ce_prev_r;

    // Shift every pin through its synchronizer chain and keep the previous
    // synced WEx/CEx for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ce_sync_r  <= {SYNC_STAGES{1'b1}};
            we_sync_r  <= {SYNC_STAGES{1'b1}};
            cle_sync_r <= {SYNC_STAGES{1'b0}};
            ale_sync_r <= {SYNC_STAGES{1'b0}};
            io_sync_r  <= {SYNC_STAGES{8'h00}};
            we_prev_r  <= 1'b1;
            ce_prev_r  <= 1'b1;
        end else begin
            ce_sync_r  <= {ce_sync_r[SYNC_STAGES-2:0], ce_pin};
            we_sync_r  <= {we_sync_r[SYNC_STAGES-2:0], we_pin};
            cle_sync_r <= {cle_sync_r[SYNC_STAGES-2:0], cle_pin};
            ale_sync_r <= {ale_sync_r[SYNC_STAGES-2:0], ale_pin};
            io_sync_r  <= {io_sync_r[SYNC_STAGES-2:0], io_pin};
            we_prev_r  <= we_sync_r[SYNC_STAGES-1];
            ce_prev_r  <= ce_sync_r[SYNC_STAGES-1];
        end
    end

    assign ce_sync  = ce_sync_r[SYNC_STAGES-1];
    assign cle_sync = cle_sync_r[SYNC_STAGES-1];
    assign ale_sync = ale_sync_r[SYNC_STAGES-1];
    assign io_sync  = io_sync_r[SYNC_STAGES-1];
    assign we_rise  = we_sync_r[SYNC_STAGES-1] & ~we_prev_r;
    assign ce_rise  = ce_sync_r[SYNC_STAGES-1] & ~ce_prev_r;

endmodule

// File: rtl/nand_latch_decoder.sv
// Target-side decoder for the NAND command/address latch protocol.
// Oversamples the NAND pins, latches a cycle on each synced WEx rising edge
// with CEx low, and reports commands and reassembled (LSB-first) addresses.
// Ports: clk; reset (async active-low); bus (slave modport) carrying the pins
// in and cmd_out/cmd_valid, addr_out/addr_valid, proto_err out. All result
// signals are registered; the valid/error outputs are single-cycle pulses.
module nand_latch_decoder
    import nand_if_pkg::*;
#(
    parameter int ADDR_BYTES  = DEFAULT_ADDR_BYTES,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    nand_latch_decoder_if.slave  bus
);
    localparam int ADDR_W = 8 * ADDR_BYTES;
    localparam int CNT_W  = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ADDR_BYTES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic              ce_sync_s;
    logic              cle_sync_s;
    logic              ale_sync_s;
    logic [7:0]        io_sync_s;
    logic              we_rise_s;
    logic              ce_rise_s;

    state_e            state_r;
    state_e            state_nxt_s;
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  count_nxt_s;
    logic [ADDR_W-1:0] shadow_r;
    logic [ADDR_W-1:0] shadow_nxt_s;
    logic [7:0]        cmd_out_r;
    logic [7:0]        cmd_out_nxt_s;
    logic [ADDR_W-1:0] addr_out_r;
    logic [ADDR_W-1:0] addr_out_nxt_s;
    logic              cmd_valid_r;
    logic              cmd_valid_nxt_s;
    logic              addr_valid_r;
    logic              addr_valid_nxt_s;
    logic              proto_err_r;
    logic              proto_err_nxt_s;
    logic              latch_s;
    cycle_kind_e       kind_s;

    nand_pin_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_pin_sync (
        .clk      (clk),
        .reset    (reset),
        .ce_pin   (bus.CEx),
        .cle_pin  (bus.CLEx),
        .ale_pin  (bus.ALEx),
        .we_pin   (bus.WEx),
        .io_pin   (bus.IOXx),
        .ce_sync  (ce_sync_s),
        .cle_sync (cle_sync_s),
        .ale_sync (ale_sync_s),
        .io_sync  (io_sync_s),
        .we_rise  (we_rise_s),
        .ce_rise  (ce_rise_s)
    );

    // Next-state, address assembly and result pulses for each latch or CEx event.
    always_comb begin
        state_nxt_s      = state_r;
        count_nxt_s      = count_r;
        shadow_nxt_s     = shadow_r;
        cmd_out_nxt_s    = cmd_out_r;
        addr_out_nxt_s   = addr_out_r;
        cmd_valid_nxt_s  = 1'b0;
        addr_valid_nxt_s = 1'b0;
        proto_err_nxt_s  = 1'b0;
        kind_s           = classify_cycle(cle_sync_s, ale_sync_s);
        // A latch needs the chip selected in the same synced stage as the edge.
        latch_s          = we_rise_s & ~ce_sync_s;

        if (latch_s) begin
            case (kind_s)
                KIND_CMD: begin
                    // A command while collecting address means the address was cut short;
                    // the new command is still accepted.
                    if (state_r == ST_ADDR) begin
                        proto_err_nxt_s = 1'b1;
                    end else begin
                        proto_err_nxt_s = 1'b0;
                    end
                    cmd_out_nxt_s   = io_sync_s;
                    cmd_valid_nxt_s = 1'b1;
                    count_nxt_s     = {CNT_W{1'b0}};
                    shadow_nxt_s    = {ADDR_W{1'b0}};
                    state_nxt_s     = ST_ADDR;
                end
                KIND_ADDR: begin
                    if (state_r == ST_IDLE) begin
                        proto_err_nxt_s = 1'b1;
                    end else begin
                        shadow_nxt_s[8*int'(count_r) +: 8] = io_sync_s;
                        if (count_r == CNT_LAST) begin
                            addr_out_nxt_s   = shadow_nxt_s;
                            addr_valid_nxt_s = 1'b1;
                            count_nxt_s      = {CNT_W{1'b0}};
                            state_nxt_s      = ST_IDLE;
                        end else begin
                            count_nxt_s = count_r + CNT_ONE;
                        end
                    end
                end
                KIND_ILLEGAL: begin
                    proto_err_nxt_s = 1'b1;
                end
                default: begin
                    // Data cycle: not ours to decode.
                    proto_err_nxt_s = 1'b0;
                end
            endcase
        end else if (ce_rise_s && (state_r == ST_ADDR)) begin
            // Deselect mid-address: drop the partial address.
            proto_err_nxt_s = 1'b1;
            count_nxt_s     = {CNT_W{1'b0}};
            shadow_nxt_s    = {ADDR_W{1'b0}};
            state_nxt_s     = ST_IDLE;
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State, shadow and registered result outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            count_r      <= {CNT_W{1'b0}};
            shadow_r     <= {ADDR_W{1'b0}};
            cmd_out_r    <= 8'h00;
            addr_out_r   <= {ADDR_W{1'b0}};
            cmd_valid_r  <= 1'b0;
            addr_valid_r <= 1'b0;
            proto_err_r  <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            count_r      <= count_nxt_s;
            shadow_r     <= shadow_nxt_s;
            cmd_out_r    <= cmd_out_nxt_s;
            addr_out_r   <= addr_out_nxt_s;
            cmd_valid_r  <= cmd_valid_nxt_s;
            addr_valid_r <= addr_valid_nxt_s;
            proto_err_r  <= proto_err_nxt_s;
        end
    end

    assign bus.cmd_out    = cmd_out_r;
    assign bus.cmd_valid  = cmd_valid_r;
    assign bus.addr_out   = addr_out_r;
    assign bus.addr_valid = addr_valid_r;
    assign bus.proto_err  = proto_err_r;

endmodule

// File: tb/tb_nand_latch_decoder.sv
// Self-checking bench for nand_latch_decoder: directed protocol scenarios
// followed by randomized cycles, all checked against a queue-based model.
module tb_nand_latch_decoder;
    import nand_if_pkg::*;

    logic clk = 1'b0;
    logic reset;

    // 100 MHz system clock.
    always #5 clk = ~clk;

    nand_latch_decoder_if bus_if ();

    nand_latch_decoder #(
        .ADDR_BYTES  (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model state.
    logic [7:0]  m_cmd;
    logic [31:0] m_addr;
    bit          m_in_addr;
    logic [7:0]  m_bytes[$];
    bit          ce_level;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_cmd     = 8'h00;
        m_addr    = 32'h0;
        m_in_addr = 1'b0;
        m_bytes.delete();
    endtask

    // Protocol rules applied to one latched bus cycle.
    task automatic model_latch(input bit cle, input bit ale, input logic [7:0] io,
                               output bit e_cmd, output bit e_addr, output bit e_err);
        e_cmd = 1'b0; e_addr = 1'b0; e_err = 1'b0;
        if (ce_level) return;
        if (cle && ale) begin
            e_err = 1'b1;
        end else if (cle) begin
            e_err     = m_in_addr;
            m_cmd     = io;
            e_cmd     = 1'b1;
            m_in_addr = 1'b1;
            m_bytes.delete();
        end else if (ale) begin
            if (!m_in_addr) begin
                e_err = 1'b1;
            end else begin
                m_bytes.push_back(io);
                if (m_bytes.size() == 4) begin
                    m_addr    = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
                    e_addr    = 1'b1;
                    m_in_addr = 1'b0;
                    m_bytes.delete();
                end
            end
        end
    endtask

    // Observe 7 cycles after a pin event: pulse counts, pulse timing, values.
    task automatic watch(input bit e_cmd, input bit e_addr, input bit e_err, input string tag);
        int n_c = 0, n_a = 0, n_e = 0;
        int t_c = -1, t_a = -1, t_e = -1;
        for (int i = 1; i <= 7; i++) begin
            @(posedge clk); #1;
            if (bus_if.cmd_valid === 1'b1)  begin n_c++; if (t_c < 0) t_c = i; end
            if (bus_if.addr_valid === 1'b1) begin n_a++; if (t_a < 0) t_a = i; end
            if (bus_if.proto_err === 1'b1)  begin n_e++; if (t_e < 0) t_e = i; end
        end
        check_val({tag, " cmd_valid pulses"}, n_c, 32'(e_cmd));
        check_val({tag, " addr_valid pulses"}, n_a, 32'(e_addr));
        check_val({tag, " proto_err pulses"}, n_e, 32'(e_err));
        if (e_cmd)  check_val({tag, " cmd_valid latency"}, t_c, 32'd3);
        if (e_addr) check_val({tag, " addr_valid latency"}, t_a, 32'd3);
        if (e_err)  check_val({tag, " proto_err latency"}, t_e, 32'd3);
        check_val({tag, " cmd_out"}, {24'h0, bus_if.cmd_out}, {24'h0, m_cmd});
        check_val({tag, " addr_out"}, bus_if.addr_out, m_addr);
    endtask

    // One WEx low/high bus cycle with the given CLE/ALE/IO.
    task automatic nand_cycle(input bit cle, input bit ale, input logic [7:0] io, input string tag);
        bit e_cmd, e_addr, e_err;
        @(negedge clk);
        bus_if.CLEx = cle;
        bus_if.ALEx = ale;
        bus_if.IOXx = io;
        bus_if.WEx  = 1'b0;
        repeat (4) @(negedge clk);
        bus_if.WEx = 1'b1;
        model_latch(cle, ale, io, e_cmd, e_addr, e_err);
        watch(e_cmd, e_addr, e_err, tag);
    endtask

    task automatic ce_set(input bit level, input string tag);
        bit e_err;
        @(negedge clk);
        e_err = level && !ce_level && m_in_addr;
        if (level && !ce_level) begin
            m_in_addr = 1'b0;
            m_bytes.delete();
        end
        ce_level   = level;
        bus_if.CEx = level;
        watch(1'b0, 1'b0, e_err, tag);
    endtask

    logic [7:0] ops [7];

    initial begin
        int n_c, n_a, n_e;
        int r;
        ops = '{OP_READ1, OP_READ2, OP_PROGRAM, OP_PROG_CONFIRM, OP_ERASE, OP_STATUS, OP_RESET};
        model_reset();
        ce_level    = 1'b0;
        reset       = 1'b0;
        bus_if.CEx  = 1'b0;
        bus_if.WEx  = 1'b0;
        bus_if.CLEx = 1'b0;
        bus_if.ALEx = 1'b0;
        bus_if.IOXx = 8'h00;

        // Reset with WEx and CEx low, then release.
        #23;
        check_val("in reset cmd_out", {24'h0, bus_if.cmd_out}, 32'h0);
        check_val("in reset addr_out", bus_if.addr_out, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        n_c = 0; n_a = 0; n_e = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus_if.cmd_valid === 1'b1)  n_c++;
            if (bus_if.addr_valid === 1'b1) n_a++;
            if (bus_if.proto_err === 1'b1)  n_e++;
        end
        check_val("post reset cmd_valid", n_c, 32'd0);
        check_val("post reset addr_valid", n_a, 32'd0);
        check_val("post reset proto_err", n_e, 32'd0);
        check_val("post reset cmd_out", {24'h0, bus_if.cmd_out}, 32'h0);
        check_val("post reset addr_out", bus_if.addr_out, 32'h0);
        @(negedge clk);
        bus_if.WEx = 1'b1;
        watch(1'b0, 1'b0, 1'b0, "data after reset");

        // Program sequence.
        nand_cycle(1'b1, 1'b0, OP_PROGRAM, "prog cmd");
        nand_cycle(1'b0, 1'b1, 8'hA8, "prog a0");
        nand_cycle(1'b0, 1'b1, 8'hA9, "prog a1");
        nand_cycle(1'b0, 1'b1, 8'hAA, "prog a2");
        nand_cycle(1'b0, 1'b1, 8'hAB, "prog a3");
        check_val("prog addr", bus_if.addr_out, 32'hABAAA9A8);

        // Command during address.
        nand_cycle(1'b1, 1'b0, OP_READ1, "cda cmd");
        nand_cycle(1'b0, 1'b1, 8'h11, "cda a0");
        nand_cycle(1'b0, 1'b1, 8'h22, "cda a1");
        nand_cycle(1'b1, 1'b0, OP_ERASE, "cda erase");
        check_val("cda addr kept", bus_if.addr_out, 32'hABAAA9A8);
        check_val("cda cmd_out", {24'h0, bus_if.cmd_out}, 32'h60);

        // CEx abort.
        nand_cycle(1'b1, 1'b0, OP_PROGRAM, "abort cmd");
        nand_cycle(1'b0, 1'b1, 8'h01, "abort a0");
        nand_cycle(1'b0, 1'b1, 8'h02, "abort a1");
        ce_set(1'b1, "abort ce high");
        ce_set(1'b0, "abort ce low");
        nand_cycle(1'b1, 1'b0, OP_STATUS, "abort status");

        // Illegal and orphan cycles, from IDLE.
        ce_set(1'b1, "to idle ce high");
        ce_set(1'b0, "to idle ce low");
        nand_cycle(1'b1, 1'b1, 8'h55, "illegal cle ale");
        nand_cycle(1'b0, 1'b1, 8'h33, "orphan addr");
        ce_set(1'b1, "idle ce high");
        nand_cycle(1'b1, 1'b0, 8'h99, "we with ce high");
        ce_set(1'b0, "idle ce low");

        // Reset mid-address.
        nand_cycle(1'b1, 1'b0, OP_PROGRAM, "mid cmd");
        nand_cycle(1'b0, 1'b1, 8'hA8, "mid a0");
        nand_cycle(1'b0, 1'b1, 8'hA9, "mid a1");
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        check_val("async reset cmd_out", {24'h0, bus_if.cmd_out}, 32'h0);
        check_val("async reset addr_out", bus_if.addr_out, 32'h0);
        check_val("async reset pulses",
                  {29'h0, bus_if.cmd_valid, bus_if.addr_valid, bus_if.proto_err}, 32'h0);
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        watch(1'b0, 1'b0, 1'b0, "after mid reset");
        nand_cycle(1'b1, 1'b0, OP_READ1, "full cmd");
        nand_cycle(1'b0, 1'b1, 8'h01, "full a0");
        nand_cycle(1'b0, 1'b1, 8'h02, "full a1");
        nand_cycle(1'b0, 1'b1, 8'h03, "full a2");
        nand_cycle(1'b0, 1'b1, 8'h04, "full a3");
        check_val("full addr", bus_if.addr_out, 32'h04030201);

        // Randomized cycles.
        for (int k = 0; k < 150; k++) begin
            r = int'($urandom_range(0, 9));
            if (r <= 1) begin
                nand_cycle(1'b1, 1'b0, ops[$urandom_range(0, 6)], "rnd cmd");
            end else if (r <= 6) begin
                nand_cycle(1'b0, 1'b1, 8'($urandom), "rnd addr");
            end else if (r == 7) begin
                nand_cycle(1'b0, 1'b0, 8'($urandom), "rnd data");
            end else if (r == 8) begin
                nand_cycle(1'b1, 1'b1, 8'($urandom), "rnd illegal");
            end else begin
                ce_set(1'b1, "rnd ce high");
                if ($urandom_range(0, 1) == 1)
                    nand_cycle(1'($urandom), 1'($urandom), 8'($urandom), "rnd ce off cycle");
                ce_set(1'b0, "rnd ce low");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/nand_latch_decoder.md
# nand_latch_decoder

Target-side decoder for the NAND command/address latch protocol driven by `address_latch_command`. It oversamples the NAND control pins (CEx, CLEx, ALEx, WEx) and IO bus on the system clock and detects WEx rising edges. Each latched cycle is classified as command or address, and a 32-bit address is reassembled byte by byte. It serves as the flash-model front end and as the loopback checker for the command/address initiator.

## Interface
- `ADDR_BYTES`, default 4: address cycles per command; address width is 8*ADDR_BYTES.
- `SYNC_STAGES`, default 2: synchronizer depth on all pin inputs (≥2).

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `CEx`  in  1  chip enable, active-low.
- `CLEx`  in  1  command latch enable, active-high.
- `ALEx`  in  1  address latch enable, active-high.
- `WEx`  in  1  write enable, active-low; data latched on its rising edge.
- `IOXx`  in  8  NAND IO bus.
- `cmd_out`  out  8  last latched command byte.
- `cmd_valid`  out  1  one-cycle pulse when `cmd_out` updates.
- `addr_out`  out  8*ADDR_BYTES  last complete address.
- `addr_valid`  out  1  one-cycle pulse when `addr_out` updates.
- `proto_err`  out  1  one-cycle pulse on a protocol violation.

## Operation
- All five pin inputs pass through SYNC_STAGES flops. WEx and CEx synchronizers reset to 1 (inactive); the others reset to 0.
- Latch event: synced WEx goes 0→1 while synced CEx = 0. IO, CLE, and ALE are taken from the same synced stage as the WEx edge.
- Classification at a latch event:
  - CLE=1, ALE=0: command.
  - CLE=0, ALE=1: address byte.
  - CLE=1, ALE=1: `proto_err`; the event is otherwise ignored.
  - CLE=0, ALE=0: data cycle; ignored with no error.
- FSM states: IDLE and ADDR.
  - IDLE + command: `cmd_out`←IO, `cmd_valid` pulses, byte count←0, go to ADDR.
  - IDLE + address byte: `proto_err`; byte discarded.
  - ADDR + address byte k: shadow[8k+7:8k]←IO (LSB first), then k++.
  - ADDR + byte k = ADDR_BYTES−1: `addr_out`←completed shadow, `addr_valid` pulses, go to IDLE.
  - ADDR + command: `proto_err` (incomplete address), then the new command is accepted as from IDLE (`cmd_valid` in the same cycle), count←0, stay in ADDR.
  - ADDR + synced CEx rising to 1: `proto_err`, shadow discarded, go to IDLE.
- `addr_out` changes only on completion; partial addresses are never visible.
- A CEx rise in IDLE is not an error.

## Timing
- Reset values: `cmd_out`=0x00, `addr_out`=0, all pulses 0, state IDLE, count 0.
- Reset acts immediately and asynchronously, including mid-address; the partial address is lost. Release causes no spurious edge.
- Latency: `cmd_valid`/`addr_valid`/`proto_err` go high at the (SYNC_STAGES+1)th rising clk edge after the first edge that samples WEx=1 at the pin.
- Pin requirements: WEx low and high phases ≥ SYNC_STAGES+1 clk periods. CLE, ALE, and IO stable from WEx fall until one clk after WEx rise. Shorter pulses are undefined.
- Pulses are exactly one cycle. Back-to-back latch events produce non-adjacent pulses.

## Structure
- Shared package `nand_if_pkg`:
  - FSM state encoding.
  - Opcode constants: READ1 0x00, READ2 0x30, PROGRAM 0x80, PROG_CONFIRM 0x10, ERASE 0x60, STATUS 0x70, RESET 0xFF.
  - Default ADDR_BYTES.
- Sub-module `nand_pin_sync`: parameterized synchronizer with the reset-value rules above, plus WEx rising-edge and CEx rising-edge detect outputs. Instantiated once.

## Test plan
- Reset check: hold reset low with WEx=0 and CEx=0, then release. Outputs remain at reset values; no pulses for 20 cycles.
- Program sequence: command 0x80, then address bytes 0xA8, 0xA9, 0xAA, 0xAB. Expect one `cmd_valid` with `cmd_out`=0x80, then one `addr_valid` with `addr_out`=0xABAAA9A8 (2880088488). `proto_err` never asserts.
- Command during address: 0x00, 0x11, 0x22, then command 0x60. Expect `proto_err` and `cmd_valid` in the same cycle with `cmd_out`=0x60. `addr_out` unchanged at its previous value.
- CEx abort: 0x80, 0x01, 0x02, then CEx high. Expect `proto_err` and no `addr_valid`. A following 0x70 gives `cmd_valid` with `cmd_out`=0x70.
- Illegal and orphan cycles:
  - CLE=ALE=1 with IO 0x55: `proto_err` only.
  - Address byte 0x33 in IDLE: `proto_err`.
  - WEx pulse with CEx=1: no response.
- Reset mid-address: 0x80, 0xA8, 0xA9, then pulse reset. All outputs return to 0. A following full sequence decodes correctly.
